// File: rtl/fpu_pkg.sv
// Shared types and helpers for the execute-stage FP issue path.
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WB
  } issueState_t;

  // Bit positions of the one-hot operation flags coming out of ID/EX.
  localparam int unsigned FLAG_ADD = 0;
  localparam int unsigned FLAG_SUB = 1;
  localparam int unsigned FLAG_MUL = 2;
  localparam int unsigned FLAG_DIV = 3;

  // Unit select encodings presented on op_sel.
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // True when exactly one flag bit is set.
  function automatic logic isOneHot(input logic [3:0] flags);
    return (flags != 4'b0000) && ((flags & (flags - 4'd1)) == 4'b0000);
  endfunction

  // Maps a one-hot flag vector onto an op_sel code; only meaningful
  // when the caller has already confirmed the flags are one-hot.
  function automatic logic [1:0] encodeOp(input logic [3:0] flags);
    logic [1:0] op;
    op = OP_ADD;
    if (flags[FLAG_SUB])      op = OP_SUB;
    else if (flags[FLAG_MUL]) op = OP_MUL;
    else if (flags[FLAG_DIV]) op = OP_DIV;
    return op;
  endfunction

endpackage

// File: rtl/ex_timeout_ctr.sv
// 8-bit WAIT-cycle counter; expire flags the last permitted WAIT cycle.
module ex_timeout_ctr #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [7:0] count;

  // Count cycles while enabled; clear takes priority over enable.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expire = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue controller: validates op flags, launches the FP unit,
// stalls ID/EX while busy, guards against hung units and hands results to WB.
module ex_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned DSIZE   = 32,
  parameter int unsigned ASIZE   = 5,
  parameter int unsigned TIMEOUT = 64   // legal range 2..255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [DSIZE-1:0] RLeftIn,
  input  logic [DSIZE-1:0] RRightIn,
  input  logic [ASIZE-1:0] RDAddressIn,
  input  logic [3:0]       FlagsIn,
  output logic             stall_out,
  output logic             op_start,
  output logic [1:0]       op_sel,
  output logic [DSIZE-1:0] op_a,
  output logic [DSIZE-1:0] op_b,
  output logic             op_abort,
  input  logic             unit_done,
  input  logic [DSIZE-1:0] unit_result,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [DSIZE-1:0] ResultOut,
  output logic [ASIZE-1:0] RDAddressOut,
  output logic             err_illegal,
  output logic             err_timeout
);

  issueState_t state;
  issueState_t nextState;

  logic flagsOneHot;
  logic flagsMulti;
  logic acceptEntry;
  logic expire;
  logic timeoutHit;

  assign flagsOneHot = isOneHot(FlagsIn);
  assign flagsMulti  = (FlagsIn != 4'b0000) && !flagsOneHot;
  assign acceptEntry = (state == IDLE) && valid_in && flagsOneHot;
  // unit_done wins over a simultaneous expiry.
  assign timeoutHit  = (state == WAIT) && !unit_done && expire;

  ex_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) uTimeout (
    .clk   (clk),
    .rst   (rst),
    .clear (state == ISSUE),
    .enable(state == WAIT),
    .expire(expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (acceptEntry) nextState = ISSUE;
      ISSUE: nextState = WAIT;
      WAIT: begin
        if (unit_done)   nextState = WB;
        else if (expire) nextState = IDLE;
      end
      WB:    if (wb_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    stall_out = (state != IDLE);
    op_start  = (state == ISSUE);
    wb_valid  = (state == WB);
  end

  // Operand/result latches and registered one-cycle error/abort pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_sel       <= '0;
      op_a         <= '0;
      op_b         <= '0;
      RDAddressOut <= '0;
      ResultOut    <= '0;
      err_illegal  <= 1'b0;
      err_timeout  <= 1'b0;
      op_abort     <= 1'b0;
    end else begin
      err_illegal <= (state == IDLE) && valid_in && flagsMulti;
      err_timeout <= timeoutHit;
      op_abort    <= timeoutHit;
      if (acceptEntry) begin
        op_sel       <= encodeOp(FlagsIn);
        op_a         <= RLeftIn;
        op_b         <= RRightIn;
        RDAddressOut <= RDAddressIn;
      end
      if ((state == WAIT) && unit_done) begin
        ResultOut <= unit_result;
      end
    end
  end

endmodule
